// File: rtl/microondas_pkg.sv
// microondas_pkg: shared state encodings, BCD digit limits and the BCD load-validity check.
package microondas_pkg;
  typedef enum logic [1:0] {
    EST_IDLE    = 2'd0,
    EST_COOKING = 2'd1,
    EST_PAUSED  = 2'd2,
    EST_DONE    = 2'd3
  } estado_t;
  localparam logic [3:0] BCD_MAX_UNID = 4'd9;
  localparam logic [3:0] BCD_MAX_DEZ  = 4'd5;
  function automatic logic bcd_valido(input logic [15:0] v);
    return (v[15:12] <= BCD_MAX_UNID) && (v[11:8] <= BCD_MAX_UNID) &&
           (v[7:4] <= BCD_MAX_DEZ) && (v[3:0] <= BCD_MAX_UNID);
  endfunction
endpackage

// File: rtl/bcd_mmss_down_counter.sv
// bcd_mmss_down_counter: mm:ss BCD time register with clear, validated load and borrow-chain decrement.
module bcd_mmss_down_counter
  import microondas_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [15:0] i_load_bcd,
  input  logic        i_dec,
  output logic [15:0] o_time_bcd,
  output logic        o_zero,
  output logic        o_one,
  output logic        o_load_ok
);
  logic [15:0] r_time;
  logic [15:0] w_dec;
  logic        w_b0, w_b1, w_b2;
  // Each w_bN means every digit up to N is zero, so the next digit must borrow.
  assign w_b0 = r_time[3:0] == 4'd0;
  assign w_b1 = w_b0 && r_time[7:4] == 4'd0;
  assign w_b2 = w_b1 && r_time[11:8] == 4'd0;
  assign w_dec[3:0]   = w_b0 ? BCD_MAX_UNID : r_time[3:0] - 4'd1;
  assign w_dec[7:4]   = !w_b0 ? r_time[7:4] : w_b1 ? BCD_MAX_DEZ : r_time[7:4] - 4'd1;
  assign w_dec[11:8]  = !w_b1 ? r_time[11:8] : w_b2 ? BCD_MAX_UNID : r_time[11:8] - 4'd1;
  assign w_dec[15:12] = !w_b2 ? r_time[15:12] : r_time[15:12] - 4'd1;
  assign o_zero     = r_time == 16'h0000;
  assign o_one      = r_time == 16'h0001;
  assign o_load_ok  = bcd_valido(i_load_bcd);
  assign o_time_bcd = r_time;
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_time <= 16'h0000;
    else if (i_clear) r_time <= 16'h0000;
    else if (i_load && o_load_ok) r_time <= i_load_bcd;
    else if (i_dec && !o_zero) r_time <= w_dec;
  end
endmodule

// File: rtl/sequenciador_cozimento.sv
// sequenciador_cozimento: microwave cook-cycle FSM with 1 Hz prescaler, key edge detect and end-of-cycle beep.
module sequenciador_cozimento
  import microondas_pkg::*;
#(
  parameter int TICK_DIV  = 100,
  parameter int BEEP_SECS = 3
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_startn,
  input  logic        i_stopn,
  input  logic        i_clearn,
  input  logic        i_door_closed,
  input  logic        i_load_en,
  input  logic [15:0] i_load_bcd,
  output logic        o_mag_on,
  output logic        o_timer_done,
  output logic        o_beep,
  output logic [15:0] o_time_bcd,
  output logic [1:0]  o_estado
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(BEEP_SECS + 1);
  estado_t        r_estado, w_prox;
  logic           r_startn_q, r_stopn_q;
  logic [PW-1:0]  r_presc;
  logic [BW-1:0]  r_beep_cnt;
  logic           w_start_ev, w_stop_ev, w_clear, w_tick, w_conta;
  logic           w_zero, w_one, w_load_ok, w_cnt_clear, w_cnt_load, w_cnt_dec;
  logic [15:0]    w_time;
  assign w_start_ev = r_startn_q && !i_startn;
  assign w_stop_ev  = r_stopn_q && !i_stopn;
  assign w_clear    = !i_clearn;
  assign w_conta    = r_estado == EST_COOKING || r_estado == EST_DONE;
  assign w_tick     = w_conta && r_presc == PW'(TICK_DIV - 1);
  // Any exit back to IDLE wipes the programmed time.
  assign w_cnt_clear = w_clear || (r_estado != EST_IDLE && w_prox == EST_IDLE);
  assign w_cnt_load  = r_estado == EST_IDLE && i_load_en && w_load_ok;
  assign w_cnt_dec   = r_estado == EST_COOKING && w_tick && i_door_closed && !w_stop_ev;
  bcd_mmss_down_counter u_cnt (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_clear    (w_cnt_clear),
    .i_load     (w_cnt_load),
    .i_load_bcd (i_load_bcd),
    .i_dec      (w_cnt_dec),
    .o_time_bcd (w_time),
    .o_zero     (w_zero),
    .o_one      (w_one),
    .o_load_ok  (w_load_ok)
  );
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_estado   <= EST_IDLE;
      r_startn_q <= 1'b1;
      r_stopn_q  <= 1'b1;
    end else begin
      r_estado   <= w_prox;
      r_startn_q <= i_startn;
      r_stopn_q  <= i_stopn;
    end
  end
  // Prescaler restarts outside COOKING/DONE so a partial second is lost on pause.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_presc <= '0;
    else r_presc <= (!w_conta || w_tick) ? '0 : r_presc + 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) r_beep_cnt <= '0;
    else if (r_estado != EST_DONE) r_beep_cnt <= '0;
    else if (w_tick && r_beep_cnt < BW'(BEEP_SECS)) r_beep_cnt <= r_beep_cnt + 1'b1;
  end
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      EST_IDLE:
        w_prox = (!w_clear && !i_load_en && w_start_ev && i_door_closed && !w_zero) ? EST_COOKING : EST_IDLE;
      EST_COOKING:
        w_prox = w_clear ? EST_IDLE :
                 (!i_door_closed || w_stop_ev) ? EST_PAUSED :
                 (w_tick && w_one) ? EST_DONE : EST_COOKING;
      EST_PAUSED:
        w_prox = w_clear ? EST_IDLE :
                 !i_door_closed ? EST_PAUSED :
                 w_stop_ev ? EST_IDLE :
                 w_start_ev ? EST_COOKING : EST_PAUSED;
      EST_DONE:
        w_prox = (w_clear || !i_door_closed || w_stop_ev) ? EST_IDLE : EST_DONE;
      default: w_prox = EST_IDLE;
    endcase
  end
  // Door interlock is combinational so the magnetron dies in the same cycle.
  always_comb begin
    o_mag_on     = r_estado == EST_COOKING && i_door_closed;
    o_timer_done = r_estado == EST_DONE;
    o_beep       = r_estado == EST_DONE && r_beep_cnt < BW'(BEEP_SECS);
    o_time_bcd   = w_time;
    o_estado     = r_estado;
  end
endmodule

// File: tb/tb_sequenciador_cozimento.sv
// tb_sequenciador_cozimento: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_sequenciador_cozimento;
  typedef struct {
    string       nome;
    logic [1:0]  est;
    logic [15:0] t;
    logic        mag;
    logic        done;
    logic        beep;
  } exp_t;
  logic        clk, resetn, startn, stopn, clearn, door_closed, load_en;
  logic [15:0] load_bcd;
  logic        mag_on, timer_done, beep;
  logic [15:0] time_bcd;
  logic [1:0]  estado;
  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  sequenciador_cozimento #(.TICK_DIV(4), .BEEP_SECS(2)) dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_startn      (startn),
    .i_stopn       (stopn),
    .i_clearn      (clearn),
    .i_door_closed (door_closed),
    .i_load_en     (load_en),
    .i_load_bcd    (load_bcd),
    .o_mag_on      (mag_on),
    .o_timer_done  (timer_done),
    .o_beep        (beep),
    .o_time_bcd    (time_bcd),
    .o_estado      (estado)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [1:0] e, input logic [15:0] t,
                     input logic m, input logic d, input logic b);
    exp_t x;
    x.nome = n; x.est = e; x.t = t; x.mag = m; x.done = d; x.beep = b;
    q.push_back(x);
  endtask
  task automatic load(input logic [15:0] v);
    load_en = 1'b1; load_bcd = v;
    step();
    load_en = 1'b0;
  endtask
  task automatic press_start();
    startn = 1'b0;
    step();
    startn = 1'b1;
  endtask
  task automatic press_stop();
    stopn = 1'b0;
    step();
    stopn = 1'b1;
  endtask
  task automatic press_clear();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if ({estado, time_bcd, mag_on, timer_done, beep} !== {e.est, e.t, e.mag, e.done, e.beep}) begin
          bad++;
          $display("FAIL %s: got est=%0d time=%h mag=%b done=%b beep=%b, want est=%0d time=%h mag=%b done=%b beep=%b",
                   e.nome, estado, time_bcd, mag_on, timer_done, beep, e.est, e.t, e.mag, e.done, e.beep);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "timeout");
  end
  initial begin
    resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; load_en = 1'b0; load_bcd = 16'h0000;
    step(); step();
    chk("reset", 2'd0, 16'h0000, 0, 0, 0);
    step();
    resetn = 1'b1;
    step();
    load(16'h0003);
    chk("load_0003", 2'd0, 16'h0003, 0, 0, 0);
    press_start();
    chk("start", 2'd1, 16'h0003, 1, 0, 0);
    repeat (3) step();
    chk("pre_tick", 2'd1, 16'h0003, 1, 0, 0);
    step();
    chk("tick1", 2'd1, 16'h0002, 1, 0, 0);
    repeat (4) step();
    chk("tick2", 2'd1, 16'h0001, 1, 0, 0);
    repeat (4) step();
    chk("done_entry", 2'd3, 16'h0000, 0, 1, 1);
    repeat (7) step();
    chk("beep_last", 2'd3, 16'h0000, 0, 1, 1);
    step();
    chk("beep_off", 2'd3, 16'h0000, 0, 1, 0);
    press_stop();
    chk("done_stop", 2'd0, 16'h0000, 0, 0, 0);
    load(16'h0100);
    press_start();
    repeat (4) step();
    chk("borrow_0059", 2'd1, 16'h0059, 1, 0, 0);
    press_clear();
    chk("cook_clear", 2'd0, 16'h0000, 0, 0, 0);
    load(16'h1000);
    press_start();
    repeat (4) step();
    chk("borrow_0959", 2'd1, 16'h0959, 1, 0, 0);
    press_clear();
    load(16'h0005);
    press_start();
    chk("cook_0005", 2'd1, 16'h0005, 1, 0, 0);
    step();
    door_closed = 1'b0;
    chk("mag_kill", 2'd1, 16'h0005, 0, 0, 0);
    step();
    chk("door_pause", 2'd2, 16'h0005, 0, 0, 0);
    repeat (5) step();
    chk("pause_hold", 2'd2, 16'h0005, 0, 0, 0);
    door_closed = 1'b1;
    step();
    chk("door_back", 2'd2, 16'h0005, 0, 0, 0);
    press_start();
    chk("resume", 2'd1, 16'h0005, 1, 0, 0);
    repeat (3) step();
    chk("resume_pre", 2'd1, 16'h0005, 1, 0, 0);
    step();
    chk("resume_tick", 2'd1, 16'h0004, 1, 0, 0);
    startn = 1'b0; stopn = 1'b0;
    step();
    startn = 1'b1; stopn = 1'b1;
    chk("stop_wins", 2'd2, 16'h0004, 0, 0, 0);
    press_clear();
    chk("pause_clear", 2'd0, 16'h0000, 0, 0, 0);
    load(16'h0012);
    chk("load_0012", 2'd0, 16'h0012, 0, 0, 0);
    load(16'h0070);
    chk("bad_s1", 2'd0, 16'h0012, 0, 0, 0);
    load(16'h0a00);
    chk("bad_m0", 2'd0, 16'h0012, 0, 0, 0);
    door_closed = 1'b0;
    press_start();
    chk("start_door_open", 2'd0, 16'h0012, 0, 0, 0);
    door_closed = 1'b1;
    press_clear();
    chk("idle_clear", 2'd0, 16'h0000, 0, 0, 0);
    press_start();
    chk("start_zero", 2'd0, 16'h0000, 0, 0, 0);
    load_en = 1'b1; load_bcd = 16'h0007; startn = 1'b0;
    step();
    load_en = 1'b0; startn = 1'b1;
    chk("load_wins", 2'd0, 16'h0007, 0, 0, 0);
    repeat (2) step();
    chk("load_wins_hold", 2'd0, 16'h0007, 0, 0, 0);
    load(16'h0009);
    press_start();
    repeat (2) step();
    chk("cook_0009", 2'd1, 16'h0009, 1, 0, 0);
    step();
    resetn = 1'b0;
    chk("async_reset", 2'd0, 16'h0000, 0, 0, 0);
    step();
    resetn = 1'b1;
    step();
    chk("after_reset", 2'd0, 16'h0000, 0, 0, 0);
    repeat (2) step();
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
